// File: rtl/rf_spill_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_spill_stack_if
// Description : Spill/fill bus between the windowed register file (master)
//               and its LIFO backing store (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_spill_stack_if #(
   parameter int NBITS = 64,
   parameter int CNT_W = 4
);
   logic             enable;
   logic             spill_req;
   logic             fill_req;
   logic [NBITS-1:0] spill_data;
   logic             spill_valid;
   logic [NBITS-1:0] fill_data;
   logic             fill_valid;
   logic             busy;
   logic             done;
   logic             full;
   logic             empty;
   logic             overflow_err;
   logic             underflow_err;
   logic [CNT_W-1:0] win_count;

   // Register-file side: issues requests and streams spill words
   modport master (
      output enable, spill_req, fill_req, spill_data, spill_valid,
      input  fill_data, fill_valid, busy, done, full, empty,
             overflow_err, underflow_err, win_count
   );

   // Backing-store side
   modport slave (
      input  enable, spill_req, fill_req, spill_data, spill_valid,
      output fill_data, fill_valid, busy, done, full, empty,
             overflow_err, underflow_err, win_count
   );
endinterface
`default_nettype wire

// File: rtl/rf_spill_stack.sv
`default_nettype none
// ============================================================================
// Module      : rf_spill_stack
// Description : LIFO backing store for the windowed register file. A spill
//               pushes one window (2*N words) streamed from the RF; a fill
//               pops the most recent window back, last word first.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_spill_stack #(
   parameter int NBITS     = 64,
   parameter int N         = 3,
   parameter int DEPTH_WIN = 8
) (
   input  wire              clk,
   input  wire              rst,
   rf_spill_stack_if.slave  bus
);

   localparam int WORDS  = DEPTH_WIN * 2 * N;
   localparam int PTR_W  = $clog2(WORDS + 1);
   localparam int CNT_W  = $clog2(DEPTH_WIN + 1);
   localparam int BEAT_W = (2 * N > 1) ? $clog2(2 * N) : 1;

   localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(2 * N - 1);
   localparam logic [CNT_W-1:0]  c_MAX_WIN   = CNT_W'(DEPTH_WIN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SPILL = 2'd1,
      S_FILL  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   sp_q, sp_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
   logic [NBITS-1:0]   fill_data_q, fill_data_d;
   logic               fill_valid_q, fill_valid_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;

   logic [NBITS-1:0]   mem_q [0:WORDS-1];
   logic               w_mem_we;
   logic               w_full;
   logic               w_empty;
   logic [PTR_W-1:0]   w_rd_ptr;

   assign w_full   = (win_cnt_q == c_MAX_WIN);
   assign w_empty  = (win_cnt_q == '0);
   // Top of stack sits one below the next free slot
   assign w_rd_ptr = sp_q - PTR_W'(1);

   // Next-state logic: hold everything by default, pulses default low
   always_comb begin
      state_d      = state_q;
      sp_d         = sp_q;
      beat_d       = beat_q;
      win_cnt_d    = win_cnt_q;
      fill_data_d  = fill_data_q;
      fill_valid_d = 1'b0;
      done_d       = 1'b0;
      ovf_d        = 1'b0;
      unf_d        = 1'b0;
      w_mem_we     = 1'b0;

      if (bus.enable) begin
         unique case (state_q)
            S_IDLE: begin
               // Spill wins over a simultaneous fill; the fill is dropped
               if (bus.spill_req) begin
                  if (!w_full) begin
                     state_d = S_SPILL;
                     beat_d  = '0;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else if (bus.fill_req) begin
                  if (!w_empty) begin
                     state_d = S_FILL;
                     beat_d  = '0;
                  end else begin
                     unf_d = 1'b1;
                  end
               end
            end

            S_SPILL: begin
               // Absent spill_valid simply stalls; there is no timeout
               if (bus.spill_valid) begin
                  w_mem_we = 1'b1;
                  sp_d     = sp_q + PTR_W'(1);
                  beat_d   = beat_q + BEAT_W'(1);
                  if (beat_q == c_LAST_BEAT) begin
                     state_d   = S_IDLE;
                     beat_d    = '0;
                     win_cnt_d = win_cnt_q + CNT_W'(1);
                     done_d    = 1'b1;
                  end
               end
            end

            S_FILL: begin
               fill_data_d  = mem_q[w_rd_ptr];
               fill_valid_d = 1'b1;
               sp_d         = w_rd_ptr;
               beat_d       = beat_q + BEAT_W'(1);
               // done lands on the same cycle as the last returned word
               if (beat_q == c_LAST_BEAT) begin
                  state_d   = S_IDLE;
                  beat_d    = '0;
                  win_cnt_d = win_cnt_q - CNT_W'(1);
                  done_d    = 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State, pointer and output registers; reset discards all stored windows
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sp_q         <= '0;
         beat_q       <= '0;
         win_cnt_q    <= '0;
         fill_data_q  <= '0;
         fill_valid_q <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sp_q         <= sp_d;
         beat_q       <= beat_d;
         win_cnt_q    <= win_cnt_d;
         fill_data_q  <= fill_data_d;
         fill_valid_q <= fill_valid_d;
         done_q       <= done_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
      end
   end

   // Stack storage; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (!rst && w_mem_we) begin
         mem_q[sp_q] <= bus.spill_data;
      end
   end

   assign bus.fill_data     = fill_data_q;
   assign bus.fill_valid    = fill_valid_q;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = done_q;
   assign bus.full          = w_full;
   assign bus.empty         = w_empty;
   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = unf_q;
   assign bus.win_count     = win_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_spill_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_spill_stack
// Description : Randomised scoreboard bench for rf_spill_stack. The driver
//               keeps a word-level LIFO model and queues the expected
//               output events with the clock edge they must appear on; a
//               monitor pops and compares whenever the DUT shows an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_spill_stack;

   localparam int NBITS = 64;
   localparam int N     = 3;
   localparam int DEPTH = 8;
   localparam int WPW   = 2 * N;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;

   rf_spill_stack_if #(.NBITS(NBITS), .CNT_W(CNT_W)) bus ();

   rf_spill_stack #(.NBITS(NBITS), .N(N), .DEPTH_WIN(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NBITS-1:0] data;
      int unsigned      cyc;
      bit               last;
   } fill_ev_t;

   fill_ev_t    q_fill[$];
   int unsigned q_sdone[$];
   int unsigned q_ovf[$];
   int unsigned q_unf[$];

   // Reference model: flat LIFO of words, windows = size / WPW
   logic [NBITS-1:0] stk[$];
   logic [NBITS-1:0] wbuf[WPW];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every observed output event must match the head of its queue
   always @(negedge clk) begin
      fill_ev_t e;
      int unsigned c;
      if (bus.fill_valid === 1'b1) begin
         if (q_fill.size() == 0) begin
            chk("fill_valid_unexpected", bus.fill_valid, 0);
         end else begin
            e = q_fill.pop_front();
            chk("fill_data", bus.fill_data, e.data);
            chk("fill_cycle", cyc, e.cyc);
            chk("fill_done", bus.done, e.last);
         end
      end else if (bus.done === 1'b1) begin
         if (q_sdone.size() == 0) begin
            chk("done_unexpected", bus.done, 0);
         end else begin
            c = q_sdone.pop_front();
            chk("spill_done_cycle", cyc, c);
         end
      end
      if (bus.overflow_err === 1'b1) begin
         if (q_ovf.size() == 0) chk("overflow_unexpected", bus.overflow_err, 0);
         else begin
            c = q_ovf.pop_front();
            chk("overflow_cycle", cyc, c);
         end
      end
      if (bus.underflow_err === 1'b1) begin
         if (q_unf.size() == 0) chk("underflow_unexpected", bus.underflow_err, 0);
         else begin
            c = q_unf.pop_front();
            chk("underflow_cycle", cyc, c);
         end
      end
   end

   task automatic clear_inputs();
      bus.enable      = 1'b1;
      bus.spill_req   = 1'b0;
      bus.fill_req    = 1'b0;
      bus.spill_valid = 1'b0;
      bus.spill_data  = '0;
   endtask

   task automatic check_idle(string tag);
      int w;
      w = stk.size() / WPW;
      chk({tag, "_win_count"}, 64'(bus.win_count), 64'(w));
      chk({tag, "_empty"}, 64'(bus.empty), 64'(w == 0));
      chk({tag, "_full"}, 64'(bus.full), 64'(w == DEPTH));
      chk({tag, "_busy"}, 64'(bus.busy), 0);
   endtask

   task automatic rand_words();
      for (int i = 0; i < WPW; i++) wbuf[i] = {$urandom, $urandom};
   endtask

   // mode 0: valid every cycle; 1: random valid and enable; 2: fixed pattern
   task automatic do_spill(int mode, bit with_fill);
      bit pat[9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
      int b;
      int k;
      bit v;
      bit en;
      bus.enable    = 1'b1;
      bus.spill_req = 1'b1;
      bus.fill_req  = with_fill;
      step();
      bus.spill_req = 1'b0;
      bus.fill_req  = 1'b0;
      if (stk.size() == DEPTH * WPW) begin
         q_ovf.push_back(cyc);
         return;
      end
      b = 0;
      k = 0;
      while (b < WPW) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = ($urandom_range(0, 2) != 0);
            default: v = pat[k];
         endcase
         en = (mode == 1) ? ($urandom_range(0, 7) != 0) : 1'b1;
         bus.enable      = en;
         bus.spill_valid = v;
         bus.spill_data  = v ? wbuf[b] : {$urandom, $urandom};
         bus.spill_req   = 1'(($urandom_range(0, 3) == 0));
         bus.fill_req    = 1'(($urandom_range(0, 3) == 0));
         step();
         if (en && v) begin
            if (b == WPW - 1) q_sdone.push_back(cyc);
            b++;
         end
         k++;
         if (k > 500) begin
            chk("spill_loop_bound", 64'(k), 0);
            break;
         end
      end
      clear_inputs();
      for (int i = 0; i < WPW; i++) stk.push_back(wbuf[i]);
   endtask

   // hold_at: beat before which enable drops for 3 cycles (-1 for none)
   task automatic do_fill(int hold_at, bit rnd_en);
      int b;
      bit en;
      fill_ev_t e;
      bus.enable   = 1'b1;
      bus.fill_req = 1'b1;
      step();
      bus.fill_req = 1'b0;
      if (stk.size() == 0) begin
         q_unf.push_back(cyc);
         return;
      end
      b = 0;
      while (b < WPW) begin
         if (b == hold_at) begin
            bus.enable = 1'b0;
            repeat (3) step();
            hold_at = -1;
         end
         en = rnd_en ? ($urandom_range(0, 5) != 0) : 1'b1;
         bus.enable      = en;
         bus.spill_valid = 1'($urandom_range(0, 1));
         bus.spill_data  = {$urandom, $urandom};
         step();
         if (en) begin
            e.data = stk.pop_back();
            e.cyc  = cyc;
            e.last = (b == WPW - 1);
            q_fill.push_back(e);
            b++;
         end
      end
      clear_inputs();
   endtask

   // Requests while enable is low must be ignored entirely
   task automatic idle_noise(int n);
      for (int i = 0; i < n; i++) begin
         bus.enable      = 1'b0;
         bus.spill_req   = 1'($urandom_range(0, 1));
         bus.fill_req    = 1'($urandom_range(0, 1));
         bus.spill_valid = 1'($urandom_range(0, 1));
         step();
      end
      clear_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      clear_inputs();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Reset state
      chk("reset_fill_valid", 64'(bus.fill_valid), 0);
      chk("reset_done", 64'(bus.done), 0);
      chk("reset_fill_data", bus.fill_data, 0);
      check_idle("reset");

      // Directed window 0x10..0x15 and its reversed fill
      for (int i = 0; i < WPW; i++) wbuf[i] = 64'(16 + i);
      do_spill(0, 1'b0);
      step();
      check_idle("spill1");
      do_fill(-1, 1'b0);
      step();
      check_idle("fill1");

      // Fill on empty: underflow only
      do_fill(-1, 1'b0);
      step();
      check_idle("underflow");

      // Gapped spill_valid pattern, then reversed fill
      rand_words();
      do_spill(2, 1'b0);
      check_idle("pattern_spill");
      do_fill(-1, 1'b0);

      // Windows A then B (B requested together with fill), two fills
      rand_words();
      do_spill(0, 1'b0);
      rand_words();
      do_spill(0, 1'b1);
      check_idle("two_windows");
      do_fill(-1, 1'b0);
      do_fill(-1, 1'b0);
      check_idle("two_fills");

      // Reset in the middle of a spill drops everything
      rand_words();
      do_spill(0, 1'b0);
      bus.spill_req = 1'b1;
      step();
      bus.spill_req   = 1'b0;
      bus.spill_valid = 1'b1;
      repeat (3) begin
         bus.spill_data = {$urandom, $urandom};
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_inputs();
      stk.delete();
      check_idle("mid_reset");
      step();
      check_idle("post_reset");

      // Enable held low for 3 cycles in the middle of a fill
      rand_words();
      do_spill(0, 1'b0);
      do_fill(2, 1'b0);
      check_idle("enable_hold");

      // Fill to capacity, then one more spill overflows
      for (int i = 0; i < DEPTH; i++) begin
         rand_words();
         do_spill(i % 3 == 0 ? 1 : 0, 1'b0);
      end
      check_idle("full");
      rand_words();
      do_spill(0, 1'b1);
      step();
      check_idle("overflow");

      // Randomised mix of operations
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            rand_words();
            do_spill(1, 1'($urandom_range(0, 1)));
         end else if (r < 8) begin
            do_fill(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WPW - 1)) : -1, 1'b1);
         end else begin
            idle_noise(int'($urandom_range(1, 4)));
         end
         check_idle("random");
      end

      // Drain and make sure every expected event was seen
      while (stk.size() != 0) do_fill(-1, 1'b0);
      repeat (4) step();
      check_idle("drained");
      chk("pending_fill", 64'(q_fill.size()), 0);
      chk("pending_spill_done", 64'(q_sdone.size()), 0);
      chk("pending_overflow", 64'(q_ovf.size()), 0);
      chk("pending_underflow", 64'(q_unf.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rf_spill_stack.md
Name: rf_spill_stack

Overview:
- Backing store for the windowed register file. It sits directly downstream of the RF's spill/fill outputs.
- On a spill it captures one window's worth of words streamed from the RF memory bus and pushes them onto an on-chip LIFO.
- On a fill it pops the most recently spilled window back to the RF, one word per cycle, in reverse order.
- It tracks how many windows are resident and flags overflow and underflow.

Parameters:
- NBITS, 64, data word width (same as RF).
- N, 3, registers per window block; each spilled window is 2*N words (IN + LOCAL).
- DEPTH_WIN, 8, maximum number of windows stored.
- Derived: WORDS = DEPTH_WIN*2*N; PTR_W = $clog2(WORDS+1); CNT_W = $clog2(DEPTH_WIN+1); BEAT_W = $clog2(2*N).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global advance; low freezes all state.
- spill_req  in  1  RF spill request (rf_spill), sampled in IDLE.
- fill_req  in  1  RF fill request (rf_fill), sampled in IDLE.
- spill_data  in  NBITS  word from RF memory bus (rf_mem_bus).
- spill_valid  in  1  spill_data valid this cycle.
- fill_data  out  NBITS  word returned to RF (rf_mem_busRead), registered.
- fill_valid  out  1  fill_data valid this cycle.
- busy  out  1  high in SPILL or FILL.
- done  out  1  one-cycle pulse at transfer completion.
- full  out  1  win_count == DEPTH_WIN.
- empty  out  1  win_count == 0.
- overflow_err  out  1  one-cycle pulse: spill refused.
- underflow_err  out  1  one-cycle pulse: fill refused.
- win_count  out  CNT_W  windows currently stored.

Behaviour:
- Reset values:
  - state = IDLE; sp = 0; beat = 0; win_count = 0.
  - fill_data = 0; fill_valid = 0; done = 0; overflow_err = 0; underflow_err = 0.
  - Memory contents are not reset.
- enable low: no state, pointer, counter or output register changes, except that pulse outputs (fill_valid, done, overflow_err, underflow_err) clear to 0. Inputs are ignored.
- FSM states: IDLE, SPILL, FILL.
- IDLE:
  - spill_req & !full -> SPILL, beat = 0.
  - spill_req & full -> stay IDLE, overflow_err = 1 next cycle.
  - Else fill_req & !empty -> FILL, beat = 0.
  - fill_req & empty -> underflow_err = 1 next cycle.
  - spill_req and fill_req together: spill has priority; fill_req is dropped.
- SPILL:
  - Each edge with spill_valid: mem[sp] <= spill_data; sp++; beat++.
  - spill_valid low stalls the transfer with no timeout.
  - The edge accepting beat 2N-1 goes to IDLE, increments win_count and registers done = 1, so done is visible the following cycle.
  - spill_req and fill_req are ignored while in SPILL.
- FILL:
  - Each edge: fill_data <= mem[sp-1]; fill_valid <= 1; sp--; beat++.
  - Output order is reverse of spill order: last spilled word first.
  - The edge producing beat 2N-1 goes to IDLE, decrements win_count and sets done = 1. done coincides with the last fill_valid.
  - fill_valid is high for exactly 2N consecutive cycles when enable stays high.
- Output flags:
  - busy is combinational from state.
  - full and empty are combinational from win_count.
  - win_count changes only on completed windows.
- Invariant: sp == win_count*2N whenever in IDLE.
- No wrap-around: sp is bounded by the full/empty checks.
- Reset mid-SPILL or mid-FILL: return to the reset state. The partial window is discarded and all stored windows are lost (win_count = 0).
- A new request may be accepted on the edge after done is set, which allows back-to-back transfers.

Test Plan:
- Spill 0x10..0x15 (N=3) with spill_valid held high -> 6 writes, done one cycle after the 6th accept, win_count = 1, empty = 0, busy low after.
- Fill after that spill -> fill_valid for 6 cycles starting one cycle after fill_req is accepted; fill_data sequence 0x15, 0x14, 0x13, 0x12, 0x11, 0x10; done with the last word; win_count = 0; empty = 1.
- Spill 8 windows (full = 1), then spill_req -> overflow_err pulse, state stays IDLE, win_count = 8. Fill_req with win_count = 0 -> underflow_err pulse, no fill_valid.
- Spill with spill_valid pattern 1,0,0,1,1,0,1,1,1 -> exactly 6 words stored in order, done only after the 6th valid beat. A subsequent fill returns them reversed.
- Spill windows A and B, then fill twice -> B's words come out reversed, then A's. Simultaneous spill_req & fill_req in IDLE -> spill taken.
- rst asserted after the 3rd spill beat -> next cycle win_count = 0, busy = 0, empty = 1, done never pulses. enable low mid-FILL for 3 cycles -> fill_valid low, sp frozen, sequence resumes intact.
